// File: rtl/inst_fetcher.sv
// Instruction fetcher: issues one I-cache request at a time, hands each word to the
// branch predictor, and queues {Inst, PC, predicted next PC} for the decoder.
module inst_fetcher #(
    parameter int          IQ_ADDR_W = 3,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ICache_Valid,
    output logic [31:0] ICache_Addr,
    input  logic        ICache_Done,
    input  logic [31:0] ICache_Inst,
    output logic        Fetcher_Ready,
    output logic [31:0] PC,
    output logic [31:0] Inst,
    input  logic [31:0] Predict_Jump,
    input  logic        Rollback_Valid,
    input  logic [31:0] Rollback_PC,
    output logic        IQ_Valid,
    output logic [31:0] IQ_Inst,
    output logic [31:0] IQ_PC,
    output logic [31:0] IQ_Pred_PC,
    input  logic        Decoder_Ready
);
    localparam int                   DEPTH      = 1 << IQ_ADDR_W;
    localparam logic [IQ_ADDR_W:0]   FULL_COUNT = (IQ_ADDR_W + 1)'(DEPTH);
    localparam logic [IQ_ADDR_W:0]   CNT_ONE    = (IQ_ADDR_W + 1)'(1);
    localparam logic [IQ_ADDR_W-1:0] PTR_ONE    = IQ_ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRED
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred_pc;
    } iq_entry_t;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          inst_q, inst_d;
    logic                 icache_valid_q, icache_valid_d;
    logic                 fetcher_ready_q, fetcher_ready_d;
    logic [IQ_ADDR_W-1:0] head_q, head_d;
    logic [IQ_ADDR_W-1:0] tail_q, tail_d;
    logic [IQ_ADDR_W:0]   count_q, count_d;
    logic                 push, pop;
    iq_entry_t            push_entry;
    iq_entry_t            head_entry;
    iq_entry_t            iq_mem [DEPTH];

    // NOTE: every signal driven here gets its default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        inst_d          = inst_q;
        icache_valid_d  = icache_valid_q;
        fetcher_ready_d = fetcher_ready_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        push            = 1'b0;
        pop             = 1'b0;
        push_entry      = '{inst: inst_q, pc: pc_q, pred_pc: Predict_Jump};

        if (rdy) begin
            fetcher_ready_d = 1'b0;
            if (Rollback_Valid) begin
                // Flush wins over everything: abort the request and empty the queue.
                state_d        = S_IDLE;
                pc_d           = Rollback_PC;
                icache_valid_d = 1'b0;
                head_d         = '0;
                tail_d         = '0;
                count_d        = '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (count_q < FULL_COUNT) begin
                            icache_valid_d = 1'b1;
                            state_d        = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (ICache_Done) begin
                            inst_d          = ICache_Inst;
                            icache_valid_d  = 1'b0;
                            fetcher_ready_d = 1'b1;
                            state_d         = S_PRED;
                        end
                    end
                    S_PRED: begin
                        push    = 1'b1;
                        pc_d    = Predict_Jump;
                        state_d = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase

                pop = (count_q != '0) && Decoder_Ready;
                if (push) tail_d = tail_q + PTR_ONE;
                if (pop)  head_d = head_q + PTR_ONE;
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            inst_q          <= '0;
            icache_valid_q  <= 1'b0;
            fetcher_ready_q <= 1'b0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            inst_q          <= inst_d;
            icache_valid_q  <= icache_valid_d;
            fetcher_ready_q <= fetcher_ready_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            iq_mem[tail_q] <= push_entry;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count_q == FULL_COUNT))
        else $error("inst_fetcher: push into a full instruction queue");

    assign head_entry    = iq_mem[head_q];
    assign ICache_Valid  = icache_valid_q;
    assign ICache_Addr   = pc_q;
    assign Fetcher_Ready = fetcher_ready_q;
    assign PC            = pc_q;
    assign Inst          = inst_q;
    assign IQ_Valid      = (count_q != '0);
    assign IQ_Inst       = head_entry.inst;
    assign IQ_PC         = head_entry.pc;
    assign IQ_Pred_PC    = head_entry.pred_pc;

endmodule
